// File: rtl/regfile_wb.sv
// Register file with writeback port, same-cycle bypass and per-register
// pending-write scoreboard. Decode is stalled while a source register still
// has an outstanding write, or while the destination's pending counter is
// saturated. A writeback that finds no pending write sets a sticky error.
module regfile_wb #(
  parameter int NREGS = 32,
  parameter int PMAX  = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn_d,
  input  logic        dec_valid,
  input  logic        dec_wr,
  input  logic [4:0]  dec_dst,
  input  logic        rwe_wb,
  input  logic [4:0]  insn_to_d,
  input  logic [31:0] dataout,
  input  logic        flush,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        stall,
  output logic        wb_err
);

  localparam int CW = (PMAX < 2) ? 1 : $clog2(PMAX + 1);
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] r_regs [NREGS];
  cnt_t        r_pend [NREGS];
  logic        r_wb_err;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  cnt_t        w_pend_rs;
  cnt_t        w_pend_rt;
  cnt_t        w_pend_dst;
  cnt_t        w_pend_wb;
  logic        w_wb_en;
  logic        w_retire;
  logic        w_orphan;
  logic        w_hzd_rs;
  logic        w_hzd_rt;
  logic        w_full_dst;
  logic        w_stall;
  logic        w_issue;

  // Indices at or above NREGS read as zero and are never written.
  function automatic logic in_range(input logic [4:0] idx);
    return (int'(idx) < NREGS);
  endfunction

  assign w_rs    = insn_d[25:21];
  assign w_rt    = insn_d[20:16];
  assign w_wb_en = rwe_wb && (insn_to_d != 5'd0);

  // Look up the pending counters for every index the current cycle touches.
  always_comb begin
    w_pend_rs  = '0;
    w_pend_rt  = '0;
    w_pend_dst = '0;
    w_pend_wb  = '0;
    if (in_range(w_rs))      w_pend_rs  = r_pend[w_rs];
    if (in_range(w_rt))      w_pend_rt  = r_pend[w_rt];
    if (in_range(dec_dst))   w_pend_dst = r_pend[dec_dst];
    if (in_range(insn_to_d)) w_pend_wb  = r_pend[insn_to_d];
  end

  // A retiring writeback clears a hazard in its own cycle when it is the
  // last outstanding write (effective count drops to zero); the data then
  // comes from the bypass path below.
  assign w_retire   = w_wb_en && (w_pend_wb != '0);
  assign w_orphan   = w_wb_en && (w_pend_wb == '0);
  assign w_hzd_rs   = (w_rs != 5'd0) && (w_pend_rs != '0) &&
                      !(w_retire && (insn_to_d == w_rs) && (w_pend_rs == cnt_t'(1)));
  assign w_hzd_rt   = (w_rt != 5'd0) && (w_pend_rt != '0) &&
                      !(w_retire && (insn_to_d == w_rt) && (w_pend_rt == cnt_t'(1)));
  assign w_full_dst = dec_wr && (dec_dst != 5'd0) && (w_pend_dst == cnt_t'(PMAX));
  assign w_stall    = dec_valid && (w_hzd_rs || w_hzd_rt || w_full_dst);
  assign w_issue    = dec_valid && !w_stall && dec_wr && (dec_dst != 5'd0) &&
                      in_range(dec_dst);

  assign stall  = w_stall;
  assign wb_err = r_wb_err;

  // Bypassed read of rs: r0 is zero, then same-cycle writeback, then the array.
  always_comb begin
    rs_data = '0;
    if (w_rs == 5'd0)                    rs_data = '0;
    else if (rwe_wb && insn_to_d == w_rs) rs_data = dataout;
    else if (in_range(w_rs))             rs_data = r_regs[w_rs];
  end

  // Bypassed read of rt, same priority as rs.
  always_comb begin
    rt_data = '0;
    if (w_rt == 5'd0)                    rt_data = '0;
    else if (rwe_wb && insn_to_d == w_rt) rt_data = dataout;
    else if (in_range(w_rt))             rt_data = r_regs[w_rt];
  end

  // Architectural register write; flush and stall do not block writeback.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en && in_range(insn_to_d)) begin
      r_regs[insn_to_d] <= dataout;
    end
  end

  // Pending-write counters: issue increments, retire decrements, both on the
  // same register cancel out; flush wipes everything. Entry 0 stays zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_issue && (dec_dst == 5'(i)) && !(w_retire && (insn_to_d == 5'(i))))
          r_pend[i] <= r_pend[i] + cnt_t'(1);
        else if (w_retire && (insn_to_d == 5'(i)) && !(w_issue && (dec_dst == 5'(i))))
          r_pend[i] <= r_pend[i] - cnt_t'(1);
      end
    end
  end

  // Sticky error for a writeback that had no matching pending write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_wb_err <= 1'b0;
    else if (!flush && w_orphan) r_wb_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: a driver issues one decode/writeback pattern per
// cycle and pushes the expected outputs from a reference model; a monitor
// pops and compares on the falling edge.
module tb_regfile_wb;

  localparam int PMAX = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] insn_d;
  logic        dec_valid;
  logic        dec_wr;
  logic [4:0]  dec_dst;
  logic        rwe_wb;
  logic [4:0]  insn_to_d;
  logic [31:0] dataout;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;

  logic [65:0] exp_q[$];
  string       tag_q[$];

  // Reference model: architectural values, outstanding-write counts, error flag.
  logic [31:0] m_reg [32];
  int          m_pend [32];
  bit          m_err;
  bit          m_stall;

  regfile_wb #(.NREGS(32), .PMAX(PMAX)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .insn_d    (insn_d),
    .dec_valid (dec_valid),
    .dec_wr    (dec_wr),
    .dec_dst   (dec_dst),
    .rwe_wb    (rwe_wb),
    .insn_to_d (insn_to_d),
    .dataout   (dataout),
    .flush     (flush),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall     (stall),
    .wb_err    (wb_err)
  );

  // Clock
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (rwe_wb && insn_to_d == r) return dataout;
    return m_reg[r];
  endfunction

  function automatic bit m_retire();
    return rwe_wb && insn_to_d != 5'd0 && m_pend[insn_to_d] > 0;
  endfunction

  function automatic bit m_hazard(input logic [4:0] r);
    int eff;
    if (r == 5'd0) return 1'b0;
    eff = m_pend[r] - ((m_retire() && insn_to_d == r) ? 1 : 0);
    return eff > 0;
  endfunction

  function automatic logic [65:0] model_outputs();
    logic [4:0] rs;
    logic [4:0] rt;
    bit st;
    rs = insn_d[25:21];
    rt = insn_d[20:16];
    st = dec_valid && (m_hazard(rs) || m_hazard(rt) ||
                       (dec_wr && dec_dst != 5'd0 && m_pend[dec_dst] == PMAX));
    m_stall = st;
    return {m_read(rs), m_read(rt), st, m_err};
  endfunction

  // Apply what the clock edge does with the inputs currently held.
  function automatic void model_commit();
    bit ret;
    bit iss;
    ret = m_retire();
    iss = dec_valid && !m_stall && dec_wr && dec_dst != 5'd0;
    if (rwe_wb && insn_to_d != 5'd0) m_reg[insn_to_d] = dataout;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      if (rwe_wb && insn_to_d != 5'd0 && m_pend[insn_to_d] == 0) m_err = 1'b1;
      if (iss) m_pend[dec_dst] = m_pend[dec_dst] + 1;
      if (ret) m_pend[insn_to_d] = m_pend[insn_to_d] - 1;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic dv, input logic dw, input logic [4:0] dst,
                       input logic we, input logic [4:0] tod,
                       input logic [31:0] d, input logic fl);
    logic [31:0] ins;
    ins        = $urandom();
    ins[25:21] = rs;
    ins[20:16] = rt;
    insn_d     = ins;
    dec_valid  = dv;
    dec_wr     = dw;
    dec_dst    = dst;
    rwe_wb     = we;
    insn_to_d  = tod;
    dataout    = d;
    flush      = fl;
  endtask

  // Push the expectation for the held inputs, then advance one clock.
  task automatic tick(input string tag);
    exp_q.push_back(model_outputs());
    tag_q.push_back(tag);
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic dv, input logic dw, input logic [4:0] dst,
                      input logic we, input logic [4:0] tod,
                      input logic [31:0] d, input logic fl, input string tag);
    drive(rs, rt, dv, dw, dst, we, tod, d, fl);
    tick(tag);
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [65:0] exp);
    checks++;
    if ({rs_data, rt_data, stall, wb_err} !== exp) begin
      failures++;
      $display("FAIL %s: got rs=%h rt=%h stall=%b err=%b, expected rs=%h rt=%h stall=%b err=%b",
               name, rs_data, rt_data, stall, wb_err,
               exp[65:34], exp[33:2], exp[1], exp[0]);
    end
  endtask

  // Assert reset between edges, check outputs before any edge, then release.
  task automatic pulse_reset(input string name);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_now(name, model_outputs());
    @(posedge clock);
    #1;
    idle();
    reset_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [65:0] exp;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        if ({rs_data, rt_data, stall, wb_err} !== exp) begin
          failures++;
          $display("FAIL %s: got rs=%h rt=%h stall=%b err=%b, expected rs=%h rt=%h stall=%b err=%b",
                   t, rs_data, rt_data, stall, wb_err,
                   exp[65:34], exp[33:2], exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1;
    idle();
    model_clear();
    #2;
    reset_n = 1'b0;
    #1;
    check_now("reset_state", model_outputs());
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(5'd1, 5'd31, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "post_reset_read");

    // Writeback to r0 is discarded and is not an orphan write.
    step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, "r0_wb");
    step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r0_after");

    // RAW hazard on r5 resolved by bypass in the writeback cycle.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, "r5_issue");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r5_stall_a");
    step(5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r5_stall_b");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, "r5_bypass");
    step(5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r5_readback");

    // Saturate r7 at PMAX, then one retire frees a slot on the next cycle.
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, "r7_issue");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, "r7_full");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 32'h7777_0001, 1'b0, "r7_retire");
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, "r7_free");
    step(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r7_pending");
    for (int i = 0; i < 3; i++)
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 32'h7777_0010 + i, 1'b0, "r7_drain");
    step(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r7_clear");

    // Simultaneous issue and retire on r9 leave its count at one.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, "r9_issue");
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'h9999_0001, 1'b0, "r9_both");
    step(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r9_still");
    step(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9999_0002, 1'b0, "r9_last");
    step(5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r9_done");

    // Flush drops pending state; a later writeback to r3 is an orphan.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, "r3_issue_a");
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, "r3_issue_b");
    step(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444_0000, 1'b1, "flush");
    step(5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r3_after_flush");
    step(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h3333_0003, 1'b0, "r3_orphan_wb");
    step(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "r3_err_sticky");

    // Asynchronous reset mid-stream with a live hazard.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, "pre_rst_issue");
    drive(5'd5, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check_now("pre_rst_hazard", model_outputs());
    pulse_reset("async_reset");
    step(5'd5, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "post_rst_read");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h6666_0006, 1'b0, "post_rst_wb");
    step(5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "post_rst_err");
    pulse_reset("reset_clears_err");

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic [4:0] tod;
      rs  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      rt  = 5'($urandom_range(0, 9));
      dst = 5'($urandom_range(0, 9));
      tod = 5'($urandom_range(0, 9));
      step(rs, rt, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), dst,
           1'($urandom_range(0, 2) == 0), tod, $urandom(),
           1'($urandom_range(0, 24) == 0), "random");
      if (i == 200) pulse_reset("random_reset");
    end

    // Read back every register pair once.
    for (int r = 0; r < 32; r += 2)
      step(5'(r), 5'(r + 1), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, "final_read");

    idle();
    #10;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
